// File: rtl/wyswietlacz_pkg.sv
// Shared constants for the 4-digit multiplexed display: segment patterns, slot encoding, anode idle value.
package wyswietlacz_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } slot_e;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/wyswietlacz_mux_bcd_7seg.sv
// Combinational BCD to common-anode 7-segment decoder; non-BCD codes render as a dash.
module bcd_7seg
    import wyswietlacz_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/wyswietlacz_mux.sv
// HH:MM multiplexed 7-segment driver with per-slot anode guard time and frame-latched digits.
// Optional colon blink on dp_o when DP_BLINK_EN is defined; otherwise dp_o is held high.
module wyswietlacz_mux
    import wyswietlacz_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYC    = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] hr1_i,
    input  logic [3:0] hr2_i,
    input  logic [3:0] min1_i,
    input  logic [3:0] min2_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYC);

    if (SCAN_DIV < GUARD_CYC + 2 || BLINK_FRAMES < 1) begin : g_param_check
        $error("wyswietlacz_mux: bad SCAN_DIV/GUARD_CYC/BLINK_FRAMES");
    end

    slot_e           slot_q, slot_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_d;
    logic            wrap, frame_end, active;
    logic [1:0]      slot_idx;
    logic [6:0]      seg_dec;

    assign wrap      = (cnt_q == CNT_LAST);
    assign frame_end = wrap && (slot_q == DIG3);
    assign active    = (cnt_q >= CNT_GUARD);
    assign slot_idx  = slot_q;

    bcd_7seg u_dec (
        .bcd_i (shadow_q[slot_idx]),
        .seg_o (seg_dec)
    );

    always_comb begin
        slot_d = slot_q;
        if (wrap) begin
            case (slot_q)
                DIG0:    slot_d = DIG1;
                DIG1:    slot_d = DIG2;
                DIG2:    slot_d = DIG3;
                DIG3:    slot_d = DIG0;
                default: slot_d = DIG0;
            endcase
        end
    end

    always_comb begin
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        // Index matches slot: 0=min2 (rightmost) .. 3=hr1
        shadow_d = frame_end ? {{2'b00, hr1_i}, hr2_i, min1_i, min2_i} : shadow_q;
        an_d     = active ? ~(4'b0001 << slot_idx) : AN_OFF;
        seg_d    = active ? seg_dec : SEG_OFF;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q   <= DIG0;
            cnt_q    <= '0;
            shadow_q <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
        end else begin
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

`ifdef DP_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic          dp_q;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        // Colon sits between HH and MM, lit with the hours-units digit
        dp_d = ~(phase_q && active && (slot_q == DIG2));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_q <= '0;
            phase_q <= 1'b0;
            dp_q    <= 1'b1;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
            dp_q    <= dp_d;
        end
    end

    assign dp_o = dp_q;
`else
    assign dp_d = 1'b1;
    assign dp_o = dp_d;
`endif

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: tb/tb_wyswietlacz_mux.sv
// Self-checking bench for wyswietlacz_mux: directed steps plus random digits, checked every cycle
// against a time-based reference model (slot/cnt derived from cycles since reset).
module tb_wyswietlacz_mux;

    localparam int SD = 8;
    localparam int GC = 2;
    localparam int BF = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] hr1_i = '0;
    logic [3:0] hr2_i = '0;
    logic [3:0] min1_i = '0;
    logic [3:0] min2_i = '0;
    logic [3:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: cycles since reset, latched digits per slot, frames completed
    int         t = 0;
    int         fc = 0;
    logic [3:0] m_shadow [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [6:0] dec_tbl [16];

    wyswietlacz_mux #(
        .SCAN_DIV     (SD),
        .GUARD_CYC    (GC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .hr1_i  (hr1_i),
        .hr2_i  (hr2_i),
        .min1_i (min1_i),
        .min2_i (min2_i),
        .an_o   (an_o),
        .seg_o  (seg_o),
        .dp_o   (dp_o)
    );

    always #5 clk = ~clk;

    function automatic int cur_cnt();
        return t % SD;
    endfunction

    function automatic int cur_slot();
        return (t / SD) % 4;
    endfunction

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    // One clock: predict from model, clock, compare every output, then advance the model.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       r;
        logic [3:0] in_d [4];
        int c, s;
        r = rst_i;
        in_d[0] = min2_i;
        in_d[1] = min1_i;
        in_d[2] = hr2_i;
        in_d[3] = {2'b00, hr1_i};
        c = cur_cnt();
        s = cur_slot();
        e_dp = 1'b1;
        if (r || c < GC) begin
            e_an  = 4'b1111;
            e_seg = 7'h7F;
        end else begin
            e_an  = 4'b1111 & ~(4'b0001 << s);
            e_seg = dec_tbl[m_shadow[s]];
`ifdef DP_BLINK_EN
            if (s == 2 && ((fc / BF) % 2) == 1) e_dp = 1'b0;
`endif
        end
        @(posedge clk);
        #1;
        chk4("an", an_o, e_an);
        chk7("seg", seg_o, e_seg);
        vectors++;
        assert (dp_o === e_dp) else begin
            miscompares++;
            $error("FAIL dp t=%0d observed=%b expected=%b", t, dp_o, e_dp);
        end
        vectors++;
        assert ($countones(~an_o) <= 1) else begin
            miscompares++;
            $error("FAIL an_onehot t=%0d observed=%b expected=at most one low", t, an_o);
        end
        if (r) begin
            t = 0;
            fc = 0;
            m_shadow = '{4'd0, 4'd0, 4'd0, 4'd0};
        end else begin
            if (t % FRAME == FRAME - 1) begin
                m_shadow = in_d;
                fc++;
            end
            t++;
        end
    endtask

    // Step until the next edge will process (slot s, cnt c); bounded.
    task automatic run_to(input int s, input int c);
        int n;
        n = 0;
        while (!(cur_slot() == s && cur_cnt() == c) && n < 4 * FRAME) begin
            step();
            n++;
        end
        vectors++;
        assert (cur_slot() == s && cur_cnt() == c) else begin
            miscompares++;
            $error("FAIL run_to observed slot=%0d cnt=%0d expected slot=%0d cnt=%0d",
                   cur_slot(), cur_cnt(), s, c);
        end
    endtask

    initial begin
        dec_tbl[0] = 7'b1000000; dec_tbl[1] = 7'b1111001;
        dec_tbl[2] = 7'b0100100; dec_tbl[3] = 7'b0110000;
        dec_tbl[4] = 7'b0011001; dec_tbl[5] = 7'b0010010;
        dec_tbl[6] = 7'b0000010; dec_tbl[7] = 7'b1111000;
        dec_tbl[8] = 7'b0000000; dec_tbl[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) dec_tbl[i] = 7'b0111111;

        // 1: reset and first frame shows 00:00 after two blank cycles
        rst_i = 1'b1;
        repeat (3) step();
        chk4("rst_an", an_o, 4'b1111);
        chk7("rst_seg", seg_o, 7'b1111111);
        rst_i = 1'b0;
        step();
        chk4("guard0_an", an_o, 4'b1111);
        step();
        chk4("guard1_an", an_o, 4'b1111);
        step();
        chk4("first_an", an_o, 4'b1110);
        chk7("first_seg", seg_o, 7'b1000000);

        // 2: 12:34 after one frame latch
        hr1_i = 2'd1; hr2_i = 4'd2; min1_i = 4'd3; min2_i = 4'd4;
        run_to(3, SD - 1);
        step();
        run_to(0, GC); step();
        chk4("d12_an0", an_o, 4'b1110); chk7("d12_seg0", seg_o, 7'b0011001);
        run_to(1, GC); step();
        chk4("d12_an1", an_o, 4'b1101); chk7("d12_seg1", seg_o, 7'b0110000);
        run_to(2, GC); step();
        chk4("d12_an2", an_o, 4'b1011); chk7("d12_seg2", seg_o, 7'b0100100);
        run_to(3, GC); step();
        chk4("d12_an3", an_o, 4'b0111); chk7("d12_seg3", seg_o, 7'b1111001);

        // 3: out-of-range digits render as dash / zero-extended hr1
        min2_i = 4'hA; hr1_i = 2'd3;
        run_to(0, 0);
        run_to(0, GC); step();
        chk7("dash_seg0", seg_o, 7'b0111111);
        run_to(3, GC); step();
        chk7("hr1_3_seg3", seg_o, 7'b0110000);

        // 4: mid-frame change is held until the next frame
        run_to(1, 3);
        min1_i = 4'd7;
        step();
        chk7("hold_seg1", seg_o, 7'b0110000);
        run_to(0, 0);
        run_to(1, GC); step();
        chk7("new_seg1", seg_o, 7'b1111000);

        // 5: reset in mid-slot restarts from slot 0 with cleared shadow
        run_to(2, 5);
        rst_i = 1'b1;
        step();
        chk4("midrst_an", an_o, 4'b1111);
        chk7("midrst_seg", seg_o, 7'h7F);
        rst_i = 1'b0;
        repeat (GC + 1) step();
        chk4("restart_an", an_o, 4'b1110);
        chk7("restart_seg", seg_o, 7'b1000000);

        // 6: random digits over many frames; dp blink and one-hot checked by the model
        for (int i = 0; i < 12 * FRAME; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                hr1_i  = 2'($urandom_range(0, 3));
                hr2_i  = 4'($urandom_range(0, 15));
                min1_i = 4'($urandom_range(0, 15));
                min2_i = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 400) == 0) rst_i = 1'b1;
            step();
            rst_i = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
